// File: rtl/bcd_scan_counter_if.sv
// Bus between the BCD scan counter and its neighbours: the count controls
// come in, and the count and scan outputs go out to the 7-segment decoder.
interface bcd_scan_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic [DIGITS-1:0]     digit_sel;
  logic [3:0]            bcd_out;

  modport master (
    output en, up, load, load_val,
    input  count, wrap, digit_sel, bcd_out
  );

  modport slave (
    input  en, up, load, load_val,
    output count, wrap, digit_sel, bcd_out
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a free-running digit scanner that
// presents one digit at a time, plus a one-hot select, to a 7-segment decoder.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bcd_scan_counter_if.slave    bus
);
  localparam int               IDX_W     = $clog2(DIGITS);
  localparam logic [15:0]      PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [15:0]         presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          digit;
  logic                carry;
  logic [DIGITS-1:0]   sel;
  logic [3:0]          bcd_sel;

  function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  // Count: load wins over en; the carry/borrow ripples through every digit
  // in one cycle and a carry out of the top digit is the wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    digit   = 4'd0;
    if (bus.load) begin
      for (int i = 0; i < DIGITS; i++)
        count_d[4*i +: 4] = bcd_sanitize(bus.load_val[4*i +: 4]);
    end else if (bus.en) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit = count_q[4*i +: 4];
        if (carry) begin
          if (bus.up) begin
            if (digit == 4'd9) digit = 4'd0;
            else begin
              digit = digit + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (digit == 4'd0) digit = 4'd9;
            else begin
              digit = digit - 4'd1;
              carry = 1'b0;
            end
          end
        end
        count_d[4*i +: 4] = digit;
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = 16'd0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Outputs decode only registered state, so there is no input-to-output path.
  always_comb begin
    sel     = '0;
    bcd_sel = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel[i]  = 1'b1;
        bcd_sel = count_q[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      presc_q <= 16'd0;
      idx_q   <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.digit_sel = sel;
  assign bus.bcd_out   = bcd_sel;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=2): table of count
// vectors plus hand-written scan, async-reset and live-digit sequences.
module tb_bcd_scan_counter;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 2;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  bcd_scan_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent scan-position model used to predict digit_sel and bcd_out.
  int sc_presc;
  int sc_idx;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_presc <= 0;
      sc_idx   <= 0;
    end else if (sc_presc == SCAN_DIV - 1) begin
      sc_presc <= 0;
      sc_idx   <= (sc_idx + 1) % DIGITS;
    end else begin
      sc_presc <= sc_presc + 1;
    end
  end

  typedef struct {
    logic        load;
    logic        en;
    logic        up;
    logic [15:0] load_val;
    logic [15:0] exp_count;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic e, input logic u,
                     input logic [15:0] lv, input logic [15:0] ec, input logic ew);
    vec_t v;
    v.load = ld; v.en = e; v.up = u; v.load_val = lv;
    v.exp_count = ec; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic e, input logic u, input logic [15:0] lv);
    bus.load = ld; bus.en = e; bus.up = u; bus.load_val = lv;
  endtask

  function automatic logic [3:0] nib(input logic [15:0] c, input int idx);
    return c[4*idx +: 4];
  endfunction

  logic [3:0] sel_seq [8];
  logic [15:0] exp_c;
  bit found;

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    sel_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};

    // Reset and scan with en = 0
    #22 reset_n = 1'b1;
    #1;
    chk("reset_count", bus.count, 16'h0000);
    chk("reset_wrap", bus.wrap, 1'b0);
    chk("scan_sel_0", bus.digit_sel, sel_seq[0]);
    chk("scan_bcd_0", bus.bcd_out, 4'd0);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk($sformatf("scan_sel_%0d", i), bus.digit_sel, sel_seq[i % 8]);
      chk($sformatf("scan_bcd_%0d", i), bus.bcd_out, 4'd0);
    end

    // Count vectors: {load, en, up, load_val, expected count, expected wrap}
    add(1, 0, 0, 16'h0999, 16'h0999, 0);
    add(0, 1, 1, 16'h0000, 16'h1000, 0);
    add(1, 0, 0, 16'h9998, 16'h9998, 0);
    add(0, 1, 1, 16'h0000, 16'h9999, 0);
    add(0, 1, 1, 16'h0000, 16'h0000, 1);
    add(0, 1, 1, 16'h0000, 16'h0001, 0);
    add(1, 0, 0, 16'h0A10, 16'h0010, 0);
    for (int k = 9; k >= 0; k--) add(0, 1, 0, 16'h0000, 16'(k), 0);
    add(0, 1, 0, 16'h0000, 16'h9999, 1);
    add(0, 0, 0, 16'h0000, 16'h9999, 0);
    add(1, 0, 0, 16'hFFFF, 16'h0000, 0);
    add(1, 1, 1, 16'h4321, 16'h4321, 0);
    add(0, 1, 1, 16'h0000, 16'h4322, 0);
    add(0, 1, 0, 16'h0000, 16'h4321, 0);
    add(0, 1, 1, 16'h0000, 16'h4322, 0);
    add(1, 0, 0, 16'h9999, 16'h9999, 0);
    add(1, 1, 1, 16'h9999, 16'h9999, 0);
    add(0, 1, 1, 16'h0000, 16'h0000, 1);
    add(0, 1, 0, 16'h0000, 16'h9999, 1);
    add(0, 0, 1, 16'h0000, 16'h9999, 0);
    add(1, 1, 0, 16'h5A7B, 16'h5070, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_val);
      cyc();
      chk($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
      chk($sformatf("vec%0d_wrap", i), bus.wrap, vecs[i].exp_wrap);
      chk($sformatf("vec%0d_sel", i), bus.digit_sel, 4'b0001 << sc_idx);
      chk($sformatf("vec%0d_bcd", i), bus.bcd_out, nib(vecs[i].exp_count, sc_idx));
    end

    // Priority load over en, then async reset between edges
    drive(1, 1, 0, 16'h4321);
    cyc();
    chk("prio_count", bus.count, 16'h4321);
    drive(0, 0, 0, 16'h0000);
    #3 reset_n = 1'b0;
    #1;
    chk("areset_count", bus.count, 16'h0000);
    chk("areset_sel", bus.digit_sel, 4'b0001);
    chk("areset_bcd", bus.bcd_out, 4'd0);
    chk("areset_wrap", bus.wrap, 1'b0);
    cyc();
    #2 reset_n = 1'b1;
    drive(0, 1, 1, 16'h0000);
    cyc();
    chk("post_reset_count", bus.count, 16'h0001);
    chk("post_reset_sel", bus.digit_sel, 4'b0001);
    chk("post_reset_wrap", bus.wrap, 1'b0);

    // Reset in the middle of a wrap pulse
    drive(1, 0, 0, 16'h9999);
    cyc();
    drive(0, 1, 1, 16'h0000);
    cyc();
    chk("midwrap_pulse", bus.wrap, 1'b1);
    drive(0, 0, 0, 16'h0000);
    #3 reset_n = 1'b0;
    #1;
    chk("midwrap_reset_wrap", bus.wrap, 1'b0);
    chk("midwrap_reset_sel", bus.digit_sel, 4'b0001);
    cyc();
    #2 reset_n = 1'b1;

    // Live digit tracking: step while digit 0 is on the bus
    drive(1, 0, 0, 16'h0005);
    cyc();
    drive(0, 0, 0, 16'h0000);
    found = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (sc_idx == 0 && sc_presc == 0) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("live_reach_digit0", found, 1'b1);
    if (found) begin
      chk("live_before_sel", bus.digit_sel, 4'b0001);
      chk("live_before_bcd", bus.bcd_out, 4'd5);
      drive(0, 1, 1, 16'h0000);
      cyc();
      drive(0, 0, 0, 16'h0000);
      exp_c = 16'h0006;
      chk("live_after_count", bus.count, exp_c);
      chk("live_after_sel", bus.digit_sel, 4'b0001);
      chk("live_after_bcd", bus.bcd_out, 4'd6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Multi-digit synchronous BCD up/down counter with a built-in digit scanner, sitting directly upstream of the BCD-to-7-segment decoder. It holds a DIGITS-wide packed BCD count and time-multiplexes one digit at a time onto a 4-bit BCD bus. It also drives a one-hot digit-select bus for a common-segment multiplexed display. The decoder converts the selected digit to segments; this block owns all state.

## Interface
- DIGITS, 4: number of BCD digits; legal range 2..8.
- SCAN_DIV, 4: clock cycles each digit stays selected; legal range 1..65535.

- clk  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset. Asserting it clears state immediately; deassertion is taken synchronously by clk.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load; has priority over en.
- load_val  in  4*DIGITS  packed BCD load value; digit 0 (least significant) is in [3:0].
- count  out  4*DIGITS  current packed BCD count.
- wrap  out  1  one-cycle registered pulse when the count wraps in either direction.
- digit_sel  out  DIGITS  one-hot, active-high select of the digit currently on bcd_out.
- bcd_out  out  4  selected BCD digit. bcd_out[3] is the MSB and drives decoder input I0; bcd_out[0] drives I3.

## Operation
- Reset values: count = 0, wrap = 0, scan index = 0, prescaler = 0, digit_sel = 1 (digit 0), bcd_out = 0.
- Per-cycle priority: load, then en, then hold.
- load = 1:
  - Each 4-bit field of load_val greater than 9 loads as 0; every other field loads as given.
  - wrap goes to 0 on the next edge.
  - The en value in that cycle is ignored.
- en = 1, up = 1:
  - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit (ripple within the same cycle).
  - All nines → all zeros, and wrap = 1 for the following cycle.
- en = 1, up = 0:
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - All zeros → all nines, and wrap = 1 for the following cycle.
- en = 0 and load = 0: count holds and wrap = 0.
- Every digit field of count is always in 0..9; no illegal code is ever produced.
- Scanner (free-running, independent of en and load):
  - The prescaler counts 0..SCAN_DIV-1.
  - On the edge where the prescaler is at SCAN_DIV-1, it returns to 0 and the scan index advances 0 → 1 → … → DIGITS-1 → 0.
  - With SCAN_DIV = 1 the index advances every cycle.
- digit_sel is the one-hot decode of the scan index registers.
- bcd_out is the count field selected by the scan index, decoded combinationally from registers (no combinational path from any input).

## Timing
- Count latency: count reflects load or en exactly one rising edge after they are sampled.
- Wrap pulse: asserts in the cycle immediately after the wrapping edge, lasts exactly one cycle, and repeats on every wrap, including back-to-back wraps.
- bcd_out tracking: bcd_out follows a count change in the same cycle that count changes, even while the digit is selected.
- Scan period: DIGITS × SCAN_DIV cycles. Each digit_sel bit is high for exactly SCAN_DIV consecutive cycles, and exactly one bit is high at all times outside reset.
- Reset mid-operation: asserting reset_n = 0 forces all outputs to their reset values without waiting for clk, including mid-scan and mid-wrap-pulse. After release, the first edge behaves as if starting from the reset state.
- load and en together: load wins; no wrap pulse results, even if the count would have wrapped.
- Direction change: up may change every cycle. Each step uses the up value sampled on that edge.

## Test plan
- Reset and scan: release reset with DIGITS = 4, SCAN_DIV = 2, en = 0. Required:
  - count = 0x0000.
  - digit_sel sequence 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, repeating.
  - bcd_out = 0 throughout.
- Carry ripple: load 0x0999, then en = 1, up = 1 for one cycle. Required: count = 0x1000, wrap stays 0.
- Up-wrap: load 0x9998, then hold en = 1, up = 1 for 3 cycles. Required:
  - count sequence 9999, 0000, 0001.
  - wrap = 1 only in the cycle where count first reads 0000.
- Down-wrap and illegal load: load 0x0A10. Required: count = 0x0010. Then count down 11 steps. Required:
  - count = 9999 on the 11th step.
  - a single wrap pulse.
- Priority and async reset: assert load = 1 with en = 1, load_val = 0x4321. Required: count = 0x4321 and no step. Then pull reset_n low between clock edges. Required:
  - count = 0, digit_sel = 0001, bcd_out = 0, wrap = 0 before the next edge.
- Live digit tracking: select digit 0 with count = 0x0005, then pulse en, up = 1. Required: bcd_out changes from 5 to 6 in the same cycle that count changes.
